// File: rtl/core_pkg.sv
// Shared definitions for the RV32I multi-cycle sequencer: state encoding,
// default wait limit and idle levels of the active-low strobes.
package core_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_MEM     = 3'd4,
    ST_WB      = 3'd5,
    ST_ERR     = 3'd6
  } state_t;

  localparam int   WAIT_MAX_DEF  = 16;
  localparam logic DM_EN_N_IDLE  = 1'b1;
  localparam logic DM_WEN_IDLE   = 1'b1;
  localparam logic RF_WEN_N_IDLE = 1'b1;

endpackage

// File: rtl/ctrl_wait_timer.sv
// Consecutive not-ready cycle counter shared by FETCH and MEM; expired_o
// flags the last allowed wait cycle (count == WAIT_MAX-1).
module ctrl_wait_timer #(
  parameter int WAIT_MAX = 16
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cnt <= '0;
    end else if (clr_i) begin
      r_cnt <= '0;
    end else if (en_i) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign expired_o = (r_cnt == CW'(WAIT_MAX - 1));

endmodule

// File: rtl/core_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WB sequencer with one instruction in
// flight; memory strobes are decoded from the state and latched decode bits.
module core_seq_ctrl
  import core_pkg::*;
#(
  parameter int WAIT_MAX = WAIT_MAX_DEF,
  parameter int CNT_W    = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic             halt_i,
  input  logic             im_ready_i,
  input  logic             dm_ready_i,
  input  logic             DM_enable_n_i,
  input  logic             DM_WEN_i,
  input  logic             REG_WEN_i,
  input  logic             Jump_en_i,
  input  logic             Branch_en_i,
  input  logic             branch_taken_i,
  output logic             im_req_o,
  output logic             ir_load_o,
  output logic             pc_wen_o,
  output logic             pc_sel_o,
  output logic             exe_latch_o,
  output logic             dm_enable_n_o,
  output logic             dm_wen_o,
  output logic             rf_wen_n_o,
  output logic [2:0]       state_o,
  output logic             busy_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] instret_o
);

  state_t           r_state;
  state_t           w_next;
  logic             r_dm_en_n;
  logic             r_dm_wen;
  logic             r_reg_wen;
  logic             r_jump;
  logic             r_branch;
  logic             r_taken;
  logic             r_timeout;
  logic [CNT_W-1:0] r_instret;
  logic             w_wait_en;
  logic             w_wait_clr;
  logic             w_expired;

  // The timer only runs on not-ready cycles; any other cycle clears it, so it
  // is always zero on entry to FETCH or MEM.
  ctrl_wait_timer #(
    .WAIT_MAX (WAIT_MAX)
  ) u_wait_timer (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .clr_i     (w_wait_clr),
    .en_i      (w_wait_en),
    .expired_o (w_expired)
  );

  always_comb begin
    w_next    = r_state;
    w_wait_en = 1'b0;
    case (r_state)
      ST_IDLE:    if (start_i) w_next = ST_FETCH;
      ST_FETCH: begin
        if (im_ready_i) begin
          w_next = ST_DECODE;
        end else begin
          w_wait_en = 1'b1;
          if (w_expired) w_next = ST_ERR;
        end
      end
      ST_DECODE:  w_next = ST_EXECUTE;
      ST_EXECUTE: w_next = r_dm_en_n ? ST_WB : ST_MEM;
      ST_MEM: begin
        if (dm_ready_i) begin
          w_next = ST_WB;
        end else begin
          w_wait_en = 1'b1;
          if (w_expired) w_next = ST_ERR;
        end
      end
      ST_WB:      w_next = halt_i ? ST_IDLE : ST_FETCH;
      ST_ERR:     w_next = ST_ERR;
      default:    w_next = ST_IDLE;
    endcase
    w_wait_clr = !w_wait_en;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state   <= ST_IDLE;
      r_dm_en_n <= 1'b0;
      r_dm_wen  <= 1'b0;
      r_reg_wen <= 1'b0;
      r_jump    <= 1'b0;
      r_branch  <= 1'b0;
      r_taken   <= 1'b0;
      r_timeout <= 1'b0;
      r_instret <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_DECODE) begin
        r_dm_en_n <= DM_enable_n_i;
        r_dm_wen  <= DM_WEN_i;
        r_reg_wen <= REG_WEN_i;
        r_jump    <= Jump_en_i;
        r_branch  <= Branch_en_i;
      end
      if (r_state == ST_EXECUTE) r_taken <= branch_taken_i;
      if (r_state == ST_WB) r_instret <= r_instret + CNT_W'(1);
      if (w_next == ST_ERR) r_timeout <= 1'b1;
    end
  end

  assign im_req_o      = (r_state == ST_FETCH);
  assign ir_load_o     = (r_state == ST_FETCH) && im_ready_i;
  assign exe_latch_o   = (r_state == ST_EXECUTE);
  assign dm_enable_n_o = (r_state == ST_MEM) ? 1'b0 : DM_EN_N_IDLE;
  assign dm_wen_o      = (r_state == ST_MEM) ? r_dm_wen : DM_WEN_IDLE;
  assign rf_wen_n_o    = (r_state == ST_WB) ? r_reg_wen : RF_WEN_N_IDLE;
  assign pc_wen_o      = (r_state == ST_WB);
  assign pc_sel_o      = (r_state == ST_WB) && (r_jump || (r_branch && r_taken));
  assign state_o       = r_state;
  assign busy_o        = (r_state != ST_IDLE) && (r_state != ST_ERR);
  assign timeout_o     = r_timeout;
  assign instret_o     = r_instret;

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Directed bench for core_seq_ctrl: a per-cycle vector table for the
// instruction mix plus hand sequences for timeouts and mid-instruction reset.
module tb_core_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, halt, im_rdy, dm_rdy;
  logic        dm_en_n_in, dm_wen_in, reg_wen_in, jump_in, branch_in, taken_in;
  logic        im_req, ir_load, pc_wen, pc_sel, exe_latch;
  logic        dm_en_n, dm_wen, rf_wen_n, busy, timeout;
  logic [2:0]  state;
  logic [31:0] instret;
  logic [9:0]  w_out;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  core_seq_ctrl #(.WAIT_MAX(16), .CNT_W(32)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .start_i        (start),
    .halt_i         (halt),
    .im_ready_i     (im_rdy),
    .dm_ready_i     (dm_rdy),
    .DM_enable_n_i  (dm_en_n_in),
    .DM_WEN_i       (dm_wen_in),
    .REG_WEN_i      (reg_wen_in),
    .Jump_en_i      (jump_in),
    .Branch_en_i    (branch_in),
    .branch_taken_i (taken_in),
    .im_req_o       (im_req),
    .ir_load_o      (ir_load),
    .pc_wen_o       (pc_wen),
    .pc_sel_o       (pc_sel),
    .exe_latch_o    (exe_latch),
    .dm_enable_n_o  (dm_en_n),
    .dm_wen_o       (dm_wen),
    .rf_wen_n_o     (rf_wen_n),
    .state_o        (state),
    .busy_o         (busy),
    .timeout_o      (timeout),
    .instret_o      (instret)
  );

  assign w_out = {im_req, ir_load, pc_wen, pc_sel, exe_latch,
                  dm_en_n, dm_wen, rf_wen_n, busy, timeout};

  // Output patterns {im_req,ir_load,pc_wen,pc_sel,exe,dm_en_n,dm_wen,rf_wen_n,busy,timeout}
  localparam logic [9:0] O_IDLE  = 10'b00000_11100;
  localparam logic [9:0] O_FWAIT = 10'b10000_11110;
  localparam logic [9:0] O_FRDY  = 10'b11000_11110;
  localparam logic [9:0] O_DEC   = 10'b00000_11110;
  localparam logic [9:0] O_EXE   = 10'b00001_11110;
  localparam logic [9:0] O_MLD   = 10'b00000_01110;
  localparam logic [9:0] O_MST   = 10'b00000_00110;
  localparam logic [9:0] O_WBR   = 10'b00100_11010;
  localparam logic [9:0] O_WBN   = 10'b00100_11110;
  localparam logic [9:0] O_WBJ   = 10'b00110_11110;
  localparam logic [9:0] O_WBRJ  = 10'b00110_11010;
  localparam logic [9:0] O_ERR   = 10'b00000_11101;

  // Decoder classes {DM_enable_n, DM_WEN, REG_WEN, Jump, Branch}
  localparam logic [4:0] D_R   = 5'b11000;
  localparam logic [4:0] D_LD  = 5'b01000;
  localparam logic [4:0] D_ST  = 5'b00100;
  localparam logic [4:0] D_BEQ = 5'b11101;
  localparam logic [4:0] D_JAL = 5'b11010;

  typedef struct {
    logic [9:0]  vi;
    logic [2:0]  st;
    logic [9:0]  out;
    logic [31:0] ir;
  } vec_t;

  vec_t tbl[35];

  function automatic logic [9:0] vin(logic s, logic h, logic ir, logic dr,
                                     logic [4:0] d, logic t);
    return {s, h, ir, dr, d, t};
  endfunction

  task automatic chk(input string nm, input logic [2:0] st,
                     input logic [9:0] o, input logic [31:0] ir);
    n_vec++;
    if (state !== st || w_out !== o || instret !== ir) begin
      n_err++;
      $display("FAIL %s: got state=%0d out=%b instret=%0d, expected state=%0d out=%b instret=%0d",
               nm, state, w_out, instret, st, o, ir);
    end else begin
      $display("vec %s ok: state=%0d out=%b instret=%0d", nm, state, w_out, instret);
    end
  endtask

  task automatic step(input logic [9:0] vi, input logic [2:0] st,
                      input logic [9:0] o, input logic [31:0] ir, input string nm);
    @(negedge clk);
    {start, halt, im_rdy, dm_rdy, dm_en_n_in, dm_wen_in,
     reg_wen_in, jump_in, branch_in, taken_in} = vi;
    #1;
    chk(nm, st, o, ir);
  endtask

  task automatic do_reset(input string nm);
    @(negedge clk);
    rst_n = 1'b0;
    {start, halt, im_rdy, dm_rdy, dm_en_n_in, dm_wen_in,
     reg_wen_in, jump_in, branch_in, taken_in} = '0;
    #1;
    chk(nm, 3'd0, O_IDLE, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{vin(1,0,1,0,D_R,0),   3'd0, O_IDLE,  32'd0};
    tbl[1]  = '{vin(0,0,1,0,D_R,0),   3'd1, O_FRDY,  32'd0};
    tbl[2]  = '{vin(0,0,0,0,D_R,0),   3'd2, O_DEC,   32'd0};
    tbl[3]  = '{vin(0,0,0,0,D_R,0),   3'd3, O_EXE,   32'd0};
    tbl[4]  = '{vin(0,0,0,0,D_R,0),   3'd5, O_WBR,   32'd0};
    tbl[5]  = '{vin(0,0,0,0,D_LD,0),  3'd1, O_FWAIT, 32'd1};
    tbl[6]  = '{vin(0,0,0,0,D_LD,0),  3'd1, O_FWAIT, 32'd1};
    tbl[7]  = '{vin(0,0,0,0,D_LD,0),  3'd1, O_FWAIT, 32'd1};
    tbl[8]  = '{vin(0,0,1,0,D_LD,0),  3'd1, O_FRDY,  32'd1};
    tbl[9]  = '{vin(0,0,0,0,D_LD,0),  3'd2, O_DEC,   32'd1};
    tbl[10] = '{vin(0,0,0,0,D_LD,0),  3'd3, O_EXE,   32'd1};
    tbl[11] = '{vin(0,0,0,0,D_LD,0),  3'd4, O_MLD,   32'd1};
    tbl[12] = '{vin(0,0,0,0,D_LD,0),  3'd4, O_MLD,   32'd1};
    tbl[13] = '{vin(0,0,0,1,D_LD,0),  3'd4, O_MLD,   32'd1};
    tbl[14] = '{vin(0,0,0,0,D_LD,0),  3'd5, O_WBR,   32'd1};
    tbl[15] = '{vin(0,0,1,0,D_ST,0),  3'd1, O_FRDY,  32'd2};
    tbl[16] = '{vin(0,0,0,0,D_ST,0),  3'd2, O_DEC,   32'd2};
    tbl[17] = '{vin(0,0,0,0,D_ST,0),  3'd3, O_EXE,   32'd2};
    tbl[18] = '{vin(0,0,0,1,D_ST,0),  3'd4, O_MST,   32'd2};
    tbl[19] = '{vin(0,0,0,0,D_ST,0),  3'd5, O_WBN,   32'd2};
    tbl[20] = '{vin(1,0,1,0,D_BEQ,0), 3'd1, O_FRDY,  32'd3};
    tbl[21] = '{vin(0,0,0,0,D_BEQ,0), 3'd2, O_DEC,   32'd3};
    tbl[22] = '{vin(0,1,0,0,D_BEQ,1), 3'd3, O_EXE,   32'd3};
    tbl[23] = '{vin(0,1,0,0,D_BEQ,0), 3'd5, O_WBJ,   32'd3};
    tbl[24] = '{vin(0,0,0,0,D_R,0),   3'd0, O_IDLE,  32'd4};
    tbl[25] = '{vin(1,0,0,0,D_R,0),   3'd0, O_IDLE,  32'd4};
    tbl[26] = '{vin(0,0,1,0,D_BEQ,0), 3'd1, O_FRDY,  32'd4};
    tbl[27] = '{vin(0,0,0,0,D_BEQ,0), 3'd2, O_DEC,   32'd4};
    tbl[28] = '{vin(0,0,0,0,D_BEQ,0), 3'd3, O_EXE,   32'd4};
    tbl[29] = '{vin(0,0,0,0,D_BEQ,1), 3'd5, O_WBN,   32'd4};
    tbl[30] = '{vin(0,0,1,0,D_JAL,0), 3'd1, O_FRDY,  32'd5};
    tbl[31] = '{vin(0,0,0,0,D_JAL,0), 3'd2, O_DEC,   32'd5};
    tbl[32] = '{vin(0,0,0,0,D_JAL,0), 3'd3, O_EXE,   32'd5};
    tbl[33] = '{vin(0,1,0,0,D_JAL,0), 3'd5, O_WBRJ,  32'd5};
    tbl[34] = '{vin(0,0,0,0,D_R,0),   3'd0, O_IDLE,  32'd6};

    rst_n = 1'b0;
    {start, halt, im_rdy, dm_rdy, dm_en_n_in, dm_wen_in,
     reg_wen_in, jump_in, branch_in, taken_in} = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset", 3'd0, O_IDLE, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 35; i++) begin
      step(tbl[i].vi, tbl[i].st, tbl[i].out, tbl[i].ir, $sformatf("tbl[%0d]", i));
    end

    // Reset asserted while a load waits in MEM
    step(vin(1,0,0,0,D_LD,0), 3'd0, O_IDLE, 32'd6, "rmem_idle");
    step(vin(0,0,1,0,D_LD,0), 3'd1, O_FRDY, 32'd6, "rmem_fetch");
    step(vin(0,0,0,0,D_LD,0), 3'd2, O_DEC,  32'd6, "rmem_dec");
    step(vin(0,0,0,0,D_LD,0), 3'd3, O_EXE,  32'd6, "rmem_exe");
    step(vin(0,0,0,0,D_LD,0), 3'd4, O_MLD,  32'd6, "rmem_mem");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rmem_async", 3'd0, O_IDLE, 32'd0);
    @(negedge clk);
    #1;
    chk("rmem_held", 3'd0, O_IDLE, 32'd0);
    rst_n = 1'b1;

    // Fetch timeout: 16 not-ready FETCH cycles then ERR
    step(vin(1,0,0,0,D_R,0), 3'd0, O_IDLE, 32'd0, "fto_start");
    for (int i = 0; i < 16; i++) begin
      step(vin(0,0,0,0,D_R,0), 3'd1, O_FWAIT, 32'd0, $sformatf("fto_wait%0d", i));
    end
    step(vin(1,0,0,0,D_R,0), 3'd6, O_ERR, 32'd0, "fto_err");
    step(vin(1,0,1,1,D_R,0), 3'd6, O_ERR, 32'd0, "fto_err_hold");
    do_reset("fto_reset");

    // Ready on the limit cycle wins over timeout
    step(vin(1,0,0,0,D_R,0), 3'd0, O_IDLE, 32'd0, "flim_start");
    for (int i = 0; i < 15; i++) begin
      step(vin(0,0,0,0,D_R,0), 3'd1, O_FWAIT, 32'd0, $sformatf("flim_wait%0d", i));
    end
    step(vin(0,0,1,0,D_R,0), 3'd1, O_FRDY, 32'd0, "flim_ready");
    step(vin(0,0,0,0,D_R,0), 3'd2, O_DEC,  32'd0, "flim_dec");
    step(vin(0,0,0,0,D_R,0), 3'd3, O_EXE,  32'd0, "flim_exe");
    step(vin(0,1,0,0,D_R,0), 3'd5, O_WBR,  32'd0, "flim_wb");
    step(vin(0,0,0,0,D_R,0), 3'd0, O_IDLE, 32'd1, "flim_idle");

    // MEM timeout on a load
    step(vin(1,0,0,0,D_LD,0), 3'd0, O_IDLE, 32'd1, "mto_start");
    step(vin(0,0,1,0,D_LD,0), 3'd1, O_FRDY, 32'd1, "mto_fetch");
    step(vin(0,0,0,0,D_LD,0), 3'd2, O_DEC,  32'd1, "mto_dec");
    step(vin(0,0,0,0,D_LD,0), 3'd3, O_EXE,  32'd1, "mto_exe");
    for (int i = 0; i < 16; i++) begin
      step(vin(0,0,0,0,D_LD,0), 3'd4, O_MLD, 32'd1, $sformatf("mto_wait%0d", i));
    end
    step(vin(0,0,0,1,D_LD,0), 3'd6, O_ERR, 32'd1, "mto_err");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
